// File: rtl/alu_wb_stage.sv
// ALU result/writeback stage: in-order result buffer, Z/C flag register and branch pulse.
// Optional pending-write scoreboard on PEND_MASK when ALU_WB_PENDMASK_EN is defined.
package alu_defs_pkg;
    typedef enum logic [3:0] {
        KADD = 4'd0,
        KSUB = 4'd1,
        KAND = 4'd2,
        kor  = 4'd3,
        KXOR = 4'd4,
        KLSH = 4'd5,
        KRSH = 4'd6,
        KLOA = 4'd7,
        KSTO = 4'd8,
        KBRZ = 4'd9,
        KNOP = 4'd15
    } op_mne;
endpackage

module alu_wb_stage
    import alu_defs_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 3
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [7:0]                 ALU_OUT,
    input  logic                       ALU_SC,
    input  logic                       ALU_ZERO,
    input  logic                       ALU_BRANCH,
    input  logic [3:0]                 IN_OP,
    input  logic [REG_AW-1:0]          IN_WADDR,
    input  logic                       IN_WEN,
    output logic                       WB_VALID,
    input  logic                       WB_READY,
    output logic [7:0]                 WB_DATA,
    output logic [REG_AW-1:0]          WB_ADDR,
    output logic                       WB_WEN,
    output logic                       FLAG_Z,
    output logic                       FLAG_C,
    output logic                       BR_TAKEN,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic [(2**REG_AW)-1:0]     PEND_MASK
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0]        data;
        logic [REG_AW-1:0] addr;
        logic              wen;
    } wb_entry_t;

    wb_entry_t         buf_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic              br_q, br_d;
    logic              push, pop, not_empty;

    // Ready is a pure function of registered occupancy, so WB_READY never reaches it.
    assign IN_READY  = (count_q < CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = not_empty && WB_READY;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        br_d     = push && ALU_BRANCH;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push) begin
            case (IN_OP)
                KADD, KSUB: begin
                    flag_z_d = ALU_ZERO;
                    flag_c_d = ALU_SC;
                end
                KAND, KXOR, kor, KLSH, KRSH: flag_z_d = ALU_ZERO;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            br_q     <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            br_q     <= br_d;
        end
    end

    // Payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge CLK) begin
        if (RESET_N && push) buf_q[tail_q] <= '{data: ALU_OUT, addr: IN_WADDR, wen: IN_WEN};
    end

    assign WB_VALID = not_empty;
    assign WB_DATA  = not_empty ? buf_q[head_q].data : '0;
    assign WB_ADDR  = not_empty ? buf_q[head_q].addr : '0;
    assign WB_WEN   = not_empty && buf_q[head_q].wen;
    assign FLAG_Z   = flag_z_q;
    assign FLAG_C   = flag_c_q;
    assign BR_TAKEN = br_q;
    assign COUNT    = count_q;

`ifdef ALU_WB_PENDMASK_EN
    logic [DEPTH-1:0] vld_q, vld_d;

    always_comb begin
        vld_d = vld_q;
        if (pop)  vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) vld_q <= '0;
        else          vld_q <= vld_d;
    end

    always_comb begin
        PEND_MASK = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && buf_q[i].wen) PEND_MASK[buf_q[i].addr] = 1'b1;
        end
    end
`else
    assign PEND_MASK = '0;
`endif

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Result/writeback stage directly downstream of the combinational ALU.
- Registers each ALU result with its destination register address into a small in-order buffer, then hands it to the register-file write port over a valid/ready handshake.
- Maintains the architectural zero/carry flag register.
- Emits a one-cycle branch-taken pulse for the fetch unit.

Parameters:
- DEPTH, 2, buffer entries; power of 2, at least 2.
- REG_AW, 3, register-file address width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- IN_VALID  in  1  ALU result presented this cycle.
- IN_READY  out  1  stage can accept; high iff occupancy < DEPTH.
- ALU_OUT  in  8  ALU OUT.
- ALU_SC  in  1  ALU SC_OUT.
- ALU_ZERO  in  1  ALU ZERO.
- ALU_BRANCH  in  1  ALU branch.
- IN_OP  in  4  opcode (op_mne encoding from definitions package).
- IN_WADDR  in  REG_AW  destination register.
- IN_WEN  in  1  instruction writes a register.
- WB_VALID  out  1  head entry valid.
- WB_READY  in  1  register file consumes head.
- WB_DATA  out  8  head data; 0 when empty.
- WB_ADDR  out  REG_AW  head address; 0 when empty.
- WB_WEN  out  1  WB_VALID and head wen.
- FLAG_Z  out  1  architectural zero flag.
- FLAG_C  out  1  architectural carry flag.
- BR_TAKEN  out  1  one-cycle branch pulse.
- COUNT  out  $clog2(DEPTH)+1  occupancy.
- PEND_MASK  out  2**REG_AW  pending-write scoreboard (see Optional Feature).

Behaviour:
- Reset (RESET_N=0 at edge):
  - occupancy 0, pointers 0, FLAG_Z=0, FLAG_C=0, BR_TAKEN=0, PEND_MASK=0.
  - Any in-flight entries are discarded.
  - Reset overrides any push/pop in the same cycle.
- Push: IN_VALID && IN_READY at an edge. The entry {ALU_OUT, IN_WADDR, IN_WEN} is written at the tail and the tail increments mod DEPTH.
- Pop: WB_VALID && WB_READY at an edge; the head increments mod DEPTH.
- Latency: an entry pushed at edge N is visible on WB_* after edge N; no same-cycle flow-through.
- IN_READY depends only on registered occupancy. There is no combinational path from WB_READY to IN_READY.
- Full (COUNT==DEPTH): IN_READY=0. A pop in the same cycle does not enable a push; the new slot is usable the following cycle.
- Empty: WB_VALID=0, WB_WEN=0, WB_DATA=0, WB_ADDR=0. WB_READY is ignored.
- Simultaneous push and pop when 0<COUNT<DEPTH: COUNT unchanged, and both pointers advance.
- Entries with IN_WEN=0 still occupy a slot and retire in order, with WB_WEN=0.
- Flags are updated on push (execute order), not on pop:
  - FLAG_Z <= ALU_ZERO when IN_OP is KADD, KSUB, KAND, KXOR, kor, KLSH or KRSH.
  - FLAG_C <= ALU_SC when IN_OP is KADD or KSUB.
  - All other opcodes leave both flags unchanged.
- BR_TAKEN: registered, high for exactly the cycle after a push with ALU_BRANCH=1. ALU_BRANCH is ignored when no push occurs.
- Back-to-back branch pushes give BR_TAKEN high for consecutive cycles.
- Pointer wrap: the pointer width is $clog2(DEPTH), so wrap is natural. COUNT never exceeds DEPTH.

Optional Feature:
- Macro: ALU_WB_PENDMASK_EN.
- Defined: PEND_MASK[r]=1 iff some valid buffered entry has wen=1 and addr=r.
  - Recomputed from registered buffer contents, so it reflects the state after the most recent edge.
  - Used by decode to stall on RAW hazards.
- Undefined: PEND_MASK is tied to 0, with no scoreboard logic synthesized.

Test Plan:
- Reset, basic push: reset low 2 cycles, then push ALU_OUT=8'h3C, IN_WADDR=5, IN_WEN=1 with WB_READY=0 -> next cycle WB_VALID=1, WB_DATA=8'h3C, WB_ADDR=5, WB_WEN=1, COUNT=1; after a pop, COUNT=0 and WB_DATA=0.
- Fill and backpressure: push 8'h11, then 8'h22 with WB_READY=0 -> COUNT=2, IN_READY=0. A third IN_VALID with 8'h33 is ignored. Raise WB_READY -> 8'h11 then 8'h22 retire in order; IN_READY returns high the cycle after the first pop.
- Flags: push KSUB with ALU_ZERO=1, ALU_SC=1 -> FLAG_Z=1, FLAG_C=1. Push KAND with ALU_ZERO=0, ALU_SC=0 -> FLAG_Z=0, FLAG_C stays 1. Push KLOA with ALU_ZERO=1 -> both flags unchanged.
- Branch pulse: push with ALU_BRANCH=1 -> BR_TAKEN=1 for exactly one cycle. Hold ALU_BRANCH=1 with IN_VALID=0 -> BR_TAKEN stays 0.
- Reset mid-operation: with COUNT=2 and FLAG_C=1, pulse RESET_N low for one cycle while IN_VALID=1 and WB_READY=1 -> next cycle COUNT=0, WB_VALID=0, FLAG_C=0, and the pushed entry is dropped.
- With ALU_WB_PENDMASK_EN defined: buffered writes to r2 and r6 (the r6 entry with IN_WEN=1) -> PEND_MASK=8'b0100_0100. An IN_WEN=0 entry to r1 does not set bit 1. After both retire, PEND_MASK=0.
